// File: rtl/kernel_line_buffer.sv
// Raster-to-column line buffer feeding the convolution kernel shifter: emits K parallel
// row channels per pixel, optionally flushing PAD zero lines so bottom windows complete.
module kernel_line_buffer #(
  parameter int unsigned IMAGE_COLUMN     = 512,
  parameter int unsigned IMAGE_ROW        = 512,
  parameter int unsigned IMAGE_DATA_WIDTH = 8,
  parameter int unsigned CONV_KERNEL_SIZE = 11,
  parameter int unsigned PAD              = 5,
  parameter string       CONV_MODE        = "same"
) (
  input  logic                                             axi_clk,
  input  logic                                             axi_rst,
  input  logic                                             in_valid,
  output logic                                             in_ready,
  input  logic [IMAGE_DATA_WIDTH-1:0]                      in_data,
  output logic [CONV_KERNEL_SIZE-1:0]                      shift_valid,
  output logic [CONV_KERNEL_SIZE-1:0][IMAGE_DATA_WIDTH-1:0] shift_data,
  output logic                                             frame_done
);

  localparam int unsigned W     = IMAGE_DATA_WIDTH;
  localparam int unsigned K     = CONV_KERNEL_SIZE;
  localparam int unsigned NumLb = K - 1;
  localparam int unsigned ColW  = (IMAGE_COLUMN > 1) ? $clog2(IMAGE_COLUMN) : 1;
  localparam int unsigned RowW  = (IMAGE_ROW > 1) ? $clog2(IMAGE_ROW) : 1;
  localparam int unsigned PadW  = (PAD > 1) ? $clog2(PAD) : 1;
  localparam bit          SameMode = (CONV_MODE == "same");

  localparam logic [ColW-1:0] LastCol   = ColW'(IMAGE_COLUMN - 1);
  localparam logic [RowW-1:0] LastRow   = RowW'(IMAGE_ROW - 1);
  localparam logic [PadW-1:0] LastFlush = PadW'(PAD - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

  state_e                 state_q, state_d;
  logic [ColW-1:0]        col_q, col_d;
  logic [RowW-1:0]        row_q, row_d;
  logic [PadW-1:0]        flush_q, flush_d;
  logic [NumLb-1:0]       rv_q, rv_d;

  logic                   step, run_step, col_wrap;
  logic [W-1:0]           x;
  logic [NumLb-1:0][W-1:0] old;
  logic [K-1:0]           valid_d;
  logic [K-1:0][W-1:0]    data_d;

  // One word per column holds that column of every line buffer; LB[j] is slice j.
  logic [NumLb-1:0][W-1:0] lb [IMAGE_COLUMN];

  assign old = lb[col_q];

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    flush_d  = flush_q;
    rv_d     = rv_q;
    step     = 1'b0;
    run_step = 1'b0;
    x        = '0;
    in_ready = (state_q == StIdle) || (state_q == StRun);

    unique case (state_q)
      StIdle, StRun: begin
        if (in_valid) begin
          step     = 1'b1;
          run_step = 1'b1;
          x        = in_data;
          state_d  = StRun;
        end
      end
      StFlush: step = 1'b1;
      StDone: begin
        state_d = StIdle;
        col_d   = '0;
        row_d   = '0;
        flush_d = '0;
        rv_d    = '0;
      end
    endcase

    col_wrap = step && (col_q == LastCol);
    if (step) col_d = col_wrap ? '0 : col_q + 1'b1;

    // A completed line shifts into the row flags; flush lines shift in as not-real.
    if (col_wrap) begin
      rv_d = {rv_q[NumLb-2:0], run_step};
      if (run_step) begin
        if (row_q == LastRow) begin
          row_d   = '0;
          state_d = SameMode ? StFlush : StDone;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        if (flush_q == LastFlush) begin
          flush_d = '0;
          state_d = StDone;
        end else begin
          flush_d = flush_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    valid_d   = step ? {rv_q, run_step} : '0;
    data_d    = '0;
    data_d[0] = x;
    for (int j = 0; j < NumLb; j++) begin
      data_d[j+1] = (step && rv_q[j]) ? old[j] : '0;
    end
  end

  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      state_q     <= StIdle;
      col_q       <= '0;
      row_q       <= '0;
      flush_q     <= '0;
      rv_q        <= '0;
      shift_valid <= '0;
      shift_data  <= '0;
      frame_done  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      flush_q     <= flush_d;
      rv_q        <= rv_d;
      shift_valid <= valid_d;
      shift_data  <= data_d;
      frame_done  <= (state_q == StDone);
    end
  end

  // Buffer contents survive reset; stale rows are masked by the row flags.
  always_ff @(posedge axi_clk) begin
    if (step) lb[col_q] <= {old[NumLb-2:0], x};
  end

endmodule

// File: tb/tb_kernel_line_buffer.sv
// Directed bench for kernel_line_buffer: 5-tap kernel over a 4x3 image, "same" and "valid".
module tb_kernel_line_buffer;

  localparam int K = 5, W = 8, NVEC = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic s_valid, v_valid, s_ready, v_ready, s_fd, v_fd;
  logic [W-1:0] s_data, v_data;
  logic [K-1:0] s_sv, v_sv;
  logic [K-1:0][W-1:0] s_sd, v_sd;

  kernel_line_buffer #(
    .IMAGE_COLUMN(4), .IMAGE_ROW(3), .IMAGE_DATA_WIDTH(W),
    .CONV_KERNEL_SIZE(K), .PAD(2), .CONV_MODE("same")
  ) dut_same (
    .axi_clk(clk), .axi_rst(rst), .in_valid(s_valid), .in_ready(s_ready),
    .in_data(s_data), .shift_valid(s_sv), .shift_data(s_sd), .frame_done(s_fd)
  );

  kernel_line_buffer #(
    .IMAGE_COLUMN(4), .IMAGE_ROW(3), .IMAGE_DATA_WIDTH(W),
    .CONV_KERNEL_SIZE(K), .PAD(2), .CONV_MODE("valid")
  ) dut_valid (
    .axi_clk(clk), .axi_rst(rst), .in_valid(v_valid), .in_ready(v_ready),
    .in_data(v_data), .shift_valid(v_sv), .shift_data(v_sd), .frame_done(v_fd)
  );

  typedef struct {
    logic [W-1:0]   din;
    bit             flush;
    logic [K-1:0]   ev;
    logic [K*W-1:0] ed;
  } vec_t;

  vec_t vecs [NVEC];
  int total = 0;
  int bad   = 0;

  function automatic vec_t mk(input logic [7:0] din, input bit flush, input logic [4:0] ev,
                              input logic [7:0] d4, input logic [7:0] d3, input logic [7:0] d2,
                              input logic [7:0] d1, input logic [7:0] d0);
    vec_t v;
    v.din   = din;
    v.flush = flush;
    v.ev    = ev;
    v.ed    = {d4, d3, d2, d1, d0};
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit vm, input logic v, input logic [W-1:0] d);
    if (vm) begin v_valid = v; v_data = d; end
    else    begin s_valid = v; s_data = d; end
  endtask

  task automatic get_out(input bit vm, output logic rdy, output logic [K-1:0] sv,
                         output logic [K*W-1:0] sd, output logic fd);
    rdy = vm ? v_ready : s_ready;
    sv  = vm ? v_sv : s_sv;
    sd  = vm ? v_sd : s_sd;
    fd  = vm ? v_fd : s_fd;
  endtask

  // Applies one table entry; flush entries optionally assert in_valid to show it is ignored.
  task automatic step_vec(input bit vm, input int i, input bit flush_valid);
    logic rdy, fd;
    logic [K-1:0] sv;
    logic [K*W-1:0] sd;
    if (vecs[i].flush) drive(vm, flush_valid, W'($urandom));
    else               drive(vm, 1'b1, vecs[i].din);
    get_out(vm, rdy, sv, sd, fd);
    chk($sformatf("ready[%0d]", i), 64'(rdy), 64'(!vecs[i].flush));
    @(posedge clk); #1;
    get_out(vm, rdy, sv, sd, fd);
    chk($sformatf("valid[%0d]", i), 64'(sv), 64'(vecs[i].ev));
    chk($sformatf("data[%0d]", i), 64'(sd), 64'(vecs[i].ed));
    chk($sformatf("done_low[%0d]", i), 64'(fd), 64'd0);
  endtask

  task automatic bubble(input bit vm);
    drive(vm, 1'b0, W'($urandom));
    @(posedge clk); #1;
    chk("bubble_valid", 64'(vm ? v_sv : s_sv), 64'd0);
    chk("bubble_data", 64'(vm ? v_sd : s_sd), 64'd0);
  endtask

  task automatic check_reset_state(input bit vm);
    logic rdy, fd;
    logic [K-1:0] sv;
    logic [K*W-1:0] sd;
    get_out(vm, rdy, sv, sd, fd);
    chk("rst_ready", 64'(rdy), 64'd1);
    chk("rst_valid", 64'(sv), 64'd0);
    chk("rst_data", 64'(sd), 64'd0);
    chk("rst_done", 64'(fd), 64'd0);
  endtask

  // Same-mode tail: DONE cycle, then a single frame_done pulse.
  task automatic same_tail();
    drive(1'b0, 1'b0, '0);
    chk("done_state_ready", 64'(s_ready), 64'd0);
    @(posedge clk); #1;
    chk("frame_done_pulse", 64'(s_fd), 64'd1);
    chk("after_done_valid", 64'(s_sv), 64'd0);
    chk("after_done_ready", 64'(s_ready), 64'd1);
    @(posedge clk); #1;
    chk("frame_done_single", 64'(s_fd), 64'd0);
  endtask

  initial begin
    for (int c = 0; c < 4; c++) begin
      vecs[c]      = mk(8'(c), 1'b0, 5'b00001, 8'h00, 8'h00, 8'h00, 8'h00, 8'(c));
      vecs[4 + c]  = mk(8'h10 + 8'(c), 1'b0, 5'b00011, 8'h00, 8'h00, 8'h00, 8'(c),
                        8'h10 + 8'(c));
      vecs[8 + c]  = mk(8'h20 + 8'(c), 1'b0, 5'b00111, 8'h00, 8'h00, 8'(c), 8'h10 + 8'(c),
                        8'h20 + 8'(c));
      vecs[12 + c] = mk(8'h00, 1'b1, 5'b01110, 8'h00, 8'(c), 8'h10 + 8'(c), 8'h20 + 8'(c),
                        8'h00);
      vecs[16 + c] = mk(8'h00, 1'b1, 5'b11100, 8'(c), 8'h10 + 8'(c), 8'h20 + 8'(c), 8'h00,
                        8'h00);
    end

    rst = 1'b1;
    drive(1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, '0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    check_reset_state(1'b0);
    check_reset_state(1'b1);

    // Frame A: continuous stream through flush.
    for (int i = 0; i < NVEC; i++) step_vec(1'b0, i, 1'b0);
    same_tail();

    // Frame B: bubbles in row 1, in_valid held high during flush.
    for (int i = 0; i < NVEC; i++) begin
      if (i >= 4 && i < 8 && (i == 5 || $urandom_range(0, 2) == 0)) bubble(1'b0);
      if (i == 6) bubble(1'b0);
      step_vec(1'b0, i, 1'b1);
    end
    same_tail();

    // Frame C: valid mode, no flush lines.
    for (int i = 0; i < 12; i++) step_vec(1'b1, i, 1'b0);
    drive(1'b1, 1'b0, '0);
    @(posedge clk); #1;
    chk("valid_mode_done", 64'(v_fd), 64'd1);
    chk("valid_mode_no_flush0", 64'(v_sv), 64'd0);
    chk("valid_mode_ready", 64'(v_ready), 64'd1);
    @(posedge clk); #1;
    chk("valid_mode_done_single", 64'(v_fd), 64'd0);
    chk("valid_mode_no_flush1", 64'(v_sv), 64'd0);

    // Frame D: reset in the middle of row 1, then a fresh frame.
    for (int i = 0; i < 6; i++) step_vec(1'b0, i, 1'b0);
    rst = 1'b1;
    drive(1'b0, 1'b1, 8'h99);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b0, 1'b0, '0);
    check_reset_state(1'b0);
    drive(1'b0, 1'b1, 8'h77);
    @(posedge clk); #1;
    chk("post_rst_valid", 64'(s_sv), 64'(5'b00001));
    chk("post_rst_data", 64'(s_sd), 64'h77);
    drive(1'b0, 1'b1, 8'h78);
    @(posedge clk); #1;
    chk("post_rst_valid2", 64'(s_sv), 64'(5'b00001));
    chk("post_rst_data2", 64'(s_sd), 64'h78);
    drive(1'b0, 1'b0, '0);
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
